// File: rtl/instr_issue_seq.sv
// Instruction issue sequencer: owns the PC, fetches instruction words over a req/valid
// handshake and holds the opcode for the controller until it signals retirement.
module instr_issue_seq #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [5:0]        HALT_OP  = 6'b111111
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [31:0]       imem_rdata,
   output logic [5:0]        input_signal,
   output logic              op_valid,
   input  logic              ctrl_done,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              fetch_hit;
   logic              issue_done;

   // Handshake inputs only count in the state that owns them.
   assign fetch_hit  = (state_q == StFetch) && imem_valid;
   assign issue_done = (state_q == StIssue) && ctrl_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: begin
            if (imem_valid) begin
               state_d = (imem_rdata[31:26] == HALT_OP) ? StHalt : StIssue;
            end
         end
         StIssue: begin
            if (ctrl_done) begin
               state_d = StFetch;
            end
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      op_valid = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         StFetch: imem_req = 1'b1;
         StIssue: op_valid = 1'b1;
         StHalt:  halted   = 1'b1;
         default: ;
      endcase
   end

   // PC and instruction latch; the PC wraps naturally at ADDR_W bits.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      if (fetch_hit) begin
         instr_d = imem_rdata;
      end
      if (issue_done) begin
         pc_d = pc_load ? pc_target : pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign pc           = pc_q;
   assign imem_addr    = pc_q;
   assign instr        = instr_q;
   assign input_signal = instr_q[31:26];

endmodule
